// File: rtl/alu_seq.sv
// Registered, handshaked ALU with iterative shifts and a signed-overflow flag.
// Optional feature macro: ALU_SEQ_MULT_EN turns op 111 into an iterative unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zout,
    output logic             vout
);

    localparam int SAW = $clog2(WIDTH);
    localparam int CW  = SAW + 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_RST = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             sc_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;

`ifdef ALU_SEQ_MULT_EN
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH:0]   mul_sum_s;

    // One shift-add step: {hi,acc} holds the partial product, acc starts as the multiplier.
    always_comb begin
        mul_sum_s = {1'b0, hi_r};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, b_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
    end
`endif

    assign add_s = {1'b0, a_r} + {1'b0, b_r};
    assign sub_s = {1'b0, a_r} - {1'b0, b_r};

    // Final result and flags from the captured operands and the shift/multiply accumulator.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (op_r)
            OP_LD:  res_s = a_r;
            OP_ADD: begin
                res_s = add_s[WIDTH-1:0];
                c_s   = add_s[WIDTH];
                v_s   = (a_r[MSB] == b_r[MSB]) && (add_s[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                res_s = sub_s[WIDTH-1:0];
                c_s   = sub_s[WIDTH];
                v_s   = (a_r[MSB] != b_r[MSB]) && (sub_s[MSB] != a_r[MSB]);
            end
            OP_NOR: res_s = ~(a_r | b_r);
            OP_SHL, OP_SHR: begin
                res_s = acc_r;
                c_s   = sc_r;
            end
`ifdef ALU_SEQ_MULT_EN
            OP_MUL: begin
                res_s = acc_r;
                c_s   = |hi_r;
            end
`endif
            default: begin
                res_s = {WIDTH{1'b0}};
                c_s   = 1'b0;
                v_s   = 1'b0;
            end
        endcase
    end

    // Control FSM, operand capture, iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            zout      <= 1'b0;
            vout      <= 1'b0;
            op_r      <= OP_RST;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            sc_r      <= 1'b0;
            cnt_r     <= {CW{1'b0}};
`ifdef ALU_SEQ_MULT_EN
            hi_r      <= {WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        acc_r    <= a;
                        sc_r     <= 1'b0;
                        in_ready <= 1'b0;
                        state_r  <= EXEC;
`ifdef ALU_SEQ_MULT_EN
                        hi_r     <= {WIDTH{1'b0}};
`endif
                        // Iteration count: shift amount for shifts, WIDTH for multiply, else none.
                        if (op == OP_SHL || op == OP_SHR) begin
                            cnt_r <= {1'b0, b[SAW-1:0]};
`ifdef ALU_SEQ_MULT_EN
                        end else if (op == OP_MUL) begin
                            cnt_r <= CW'(WIDTH);
`endif
                        end else begin
                            cnt_r <= {CW{1'b0}};
                        end
                    end
                end
                EXEC: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        case (op_r)
                            OP_SHL: begin
                                sc_r  <= acc_r[MSB];
                                acc_r <= {acc_r[WIDTH-2:0], 1'b0};
                            end
                            OP_SHR: begin
                                sc_r  <= acc_r[0];
                                acc_r <= {1'b0, acc_r[WIDTH-1:1]};
                            end
`ifdef ALU_SEQ_MULT_EN
                            OP_MUL: begin
                                hi_r  <= mul_sum_s[WIDTH:1];
                                acc_r <= {mul_sum_s[0], acc_r[WIDTH-1:1]};
                            end
`endif
                            default: acc_r <= acc_r;
                        endcase
                    end else begin
                        result    <= res_s;
                        cout      <= c_s;
                        zout      <= (res_s == {WIDTH{1'b0}});
                        vout      <= v_s;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
